// File: rtl/dc_full_detector_multi.sv
// Write-domain full / almost-full detector for one-hot-pointer dual-clock FIFOs.
// Free-slot distance flags are formed locally and only single-bit flags are synchronised.
module dc_full_detector_multi #(
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AF_W         = $clog2(BUFFER_DEPTH),
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUFFER_DEPTH-1:0] read_pointer,
  input  logic [BUFFER_DEPTH-1:0] write_pointer,
  input  logic                    valid,
  input  logic [AF_W-1:0]         af_level,
  input  logic                    clr,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int unsigned D = BUFFER_DEPTH;

  logic [D-1:0]           dist_hit;
  logic [D-1:0]           af_hit;
  logic                   full_dn;
  logic                   af_dn;

  logic [SYNC_STAGES-1:0] full_sync_q, full_sync_d;
  logic [SYNC_STAGES-1:0] af_sync_q, af_sync_d;
  logic                   latched_q, latched_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic                   full_up;

  // dist_hit[k]: some read bit sits k+1 places above a write bit, i.e. free == k
  for (genvar k = 0; k < D; k++) begin : g_dist
    localparam int unsigned K   = k;
    localparam int unsigned ROT = (K + 1) % D;
    if (ROT == 0) begin : g_rot_full
      assign dist_hit[k] = |(read_pointer & write_pointer);
    end else begin : g_rot
      assign dist_hit[k] = |(read_pointer &
                             {write_pointer[D-1-ROT:0], write_pointer[D-1:D-ROT]});
    end
    assign af_hit[k] = dist_hit[k] & (K <= 32'(af_level));
  end

  assign full_dn = |dist_hit[GUARD:0];
  assign af_dn   = |af_hit;

  assign full_up = full_sync_q[SYNC_STAGES-1];

  // A fresh full_up is held off one cycle unless a write was accepted just before it.
  always_comb begin
    full_sync_d = {full_sync_q[SYNC_STAGES-2:0], full_dn};
    af_sync_d   = {af_sync_q[SYNC_STAGES-2:0], af_dn};
    latched_d   = full_up | valid;
    overflow_d  = overflow_q;
    stall_cnt_d = stall_cnt_q;

    if (valid && full) begin
      overflow_d = 1'b1;
    end else if (clr) begin
      overflow_d = 1'b0;
    end

    if (clr) begin
      stall_cnt_d = '0;
    end else if (full && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_sync_q <= '0;
      af_sync_q   <= '0;
      latched_q   <= 1'b0;
      overflow_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      full_sync_q <= full_sync_d;
      af_sync_q   <= af_sync_d;
      latched_q   <= latched_d;
      overflow_q  <= overflow_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Falling edge of full follows full_up with no extra delay.
  assign full        = latched_q & full_up;
  assign almost_full = af_sync_q[SYNC_STAGES-1];
  assign overflow    = overflow_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_dc_full_detector_multi.sv
// Bench for dc_full_detector_multi: three parameterisations checked against a
// distance-based reference model plus vector tables and directed corner sequences.
module tb_dc_full_detector_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, clr;
  logic [7:0]  rp8, wp8;
  logic [2:0]  af8;
  logic [15:0] rp16, wp16;
  logic [3:0]  af16;

  logic        full0, afull0, ovf0;
  logic [15:0] cnt0;
  logic        full1, afull1, ovf1;
  logic [3:0]  cnt1;
  logic        full2, afull2, ovf2;
  logic [7:0]  cnt2;

  dc_full_detector_multi #(.BUFFER_DEPTH(8), .GUARD(2), .SYNC_STAGES(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .read_pointer(rp8), .write_pointer(wp8), .valid(valid),
    .af_level(af8), .clr(clr), .full(full0), .almost_full(afull0), .overflow(ovf0),
    .stall_cnt(cnt0));

  dc_full_detector_multi #(.BUFFER_DEPTH(8), .GUARD(0), .SYNC_STAGES(3), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .read_pointer(rp8), .write_pointer(wp8), .valid(valid),
    .af_level(af8), .clr(clr), .full(full1), .almost_full(afull1), .overflow(ovf1),
    .stall_cnt(cnt1));

  dc_full_detector_multi #(.BUFFER_DEPTH(16), .GUARD(2), .SYNC_STAGES(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .read_pointer(rp16), .write_pointer(wp16), .valid(valid),
    .af_level(af16), .clr(clr), .full(full2), .almost_full(afull2), .overflow(ovf2),
    .stall_cnt(cnt2));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state, one slot per instance
  int P_D[3]    = '{8, 8, 16};
  int P_G[3]    = '{2, 0, 2};
  int P_S[3]    = '{2, 3, 2};
  int P_CMAX[3] = '{65535, 15, 255};
  bit m_fsh[3][4];
  bit m_ash[3][4];
  bit m_lat[3];
  bit m_ovf[3];
  int m_cnt[3];

  typedef struct {
    logic [7:0] rp;
    logic [7:0] wp;
    logic [2:0] af;
    bit         f_g2;
    bit         f_g0;
    bit         af_o;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_full(input int i);
    return m_lat[i] & m_fsh[i][P_S[i]-1];
  endfunction

  task automatic model_step(input int i, input logic [15:0] rp, input logic [15:0] wp,
                            input int af);
    int d, f;
    bit fdn, adn, full_now, full_up;
    d = P_D[i];
    full_now = m_full(i);
    full_up  = m_fsh[i][P_S[i]-1];
    if (rst) begin
      for (int j = 0; j < 4; j++) begin
        m_fsh[i][j] = 1'b0;
        m_ash[i][j] = 1'b0;
      end
      m_lat[i] = 1'b0;
      m_ovf[i] = 1'b0;
      m_cnt[i] = 0;
    end else begin
      fdn = 1'b0;
      adn = 1'b0;
      for (int r = 0; r < d; r++) begin
        for (int w = 0; w < d; w++) begin
          if (rp[r] && wp[w]) begin
            f = (r - w - 1 + 2 * d) % d;
            if (f <= P_G[i]) fdn = 1'b1;
            if (f <= af) adn = 1'b1;
          end
        end
      end
      m_lat[i] = full_up | valid;
      for (int j = 3; j > 0; j--) begin
        m_fsh[i][j] = m_fsh[i][j-1];
        m_ash[i][j] = m_ash[i][j-1];
      end
      m_fsh[i][0] = fdn;
      m_ash[i][0] = adn;
      if (valid && full_now) m_ovf[i] = 1'b1;
      else if (clr) m_ovf[i] = 1'b0;
      if (clr) m_cnt[i] = 0;
      else if (full_now && m_cnt[i] < P_CMAX[i]) m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  // Advance one clock, update the model, then compare every output of every instance
  task automatic cycle();
    @(posedge clk);
    model_step(0, {8'h00, rp8}, {8'h00, wp8}, int'(af8));
    model_step(1, {8'h00, rp8}, {8'h00, wp8}, int'(af8));
    model_step(2, rp16, wp16, int'(af16));
    cyc++;
    #1;
    chk("m0.full", 32'(full0), 32'(m_full(0)));
    chk("m0.almost_full", 32'(afull0), 32'(m_ash[0][P_S[0]-1]));
    chk("m0.overflow", 32'(ovf0), 32'(m_ovf[0]));
    chk("m0.stall_cnt", 32'(cnt0), 32'(m_cnt[0]));
    chk("m1.full", 32'(full1), 32'(m_full(1)));
    chk("m1.almost_full", 32'(afull1), 32'(m_ash[1][P_S[1]-1]));
    chk("m1.overflow", 32'(ovf1), 32'(m_ovf[1]));
    chk("m1.stall_cnt", 32'(cnt1), 32'(m_cnt[1]));
    chk("m2.full", 32'(full2), 32'(m_full(2)));
    chk("m2.almost_full", 32'(afull2), 32'(m_ash[2][P_S[2]-1]));
    chk("m2.overflow", 32'(ovf2), 32'(m_ovf[2]));
    chk("m2.stall_cnt", 32'(cnt2), 32'(m_cnt[2]));
  endtask

  initial begin
    // rp, wp, af_level, full(GUARD=2), full(GUARD=0), almost_full
    tbl[0]  = '{8'h01, 8'h80, 3'd3, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{8'h01, 8'h40, 3'd3, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{8'h01, 8'h20, 3'd3, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{8'h01, 8'h10, 3'd3, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{8'h01, 8'h08, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h01, 8'h01, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h04, 8'h02, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{8'h04, 8'h04, 3'd7, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{8'h80, 8'h08, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h10, 8'h20, 3'd6, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{8'h11, 8'h02, 3'd1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; valid = 1'b0; clr = 1'b0;
    rp8 = 8'h04; wp8 = 8'h02; af8 = 3'd0;
    rp16 = 16'h0001; wp16 = 16'h0001; af16 = 4'd0;

    // Reset with a free==0 pointer pair
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst.full", 32'(full0), 32'd0);
      chk("rst.almost_full", 32'(afull0), 32'd0);
      chk("rst.overflow", 32'(ovf0), 32'd0);
      chk("rst.stall_cnt", 32'(cnt0), 32'd0);
    end
    rst = 1'b0;
    cycle();
    chk("post_rst.e1.full", 32'(full0), 32'd0);
    cycle();
    chk("post_rst.e2.full", 32'(full0), 32'd0);
    chk("post_rst.e2.almost_full", 32'(afull0), 32'd1);
    cycle();
    chk("post_rst.e3.full", 32'(full0), 32'd1);

    // Vector table: steady-state flags for each pointer pair
    foreach (tbl[i]) begin
      rp8 = tbl[i].rp; wp8 = tbl[i].wp; af8 = tbl[i].af;
      repeat (5) cycle();
      chk($sformatf("tbl%0d.full_g2", i), 32'(full0), 32'(tbl[i].f_g2));
      chk($sformatf("tbl%0d.full_g0", i), 32'(full1), 32'(tbl[i].f_g0));
      chk($sformatf("tbl%0d.af_s2", i), 32'(afull0), 32'(tbl[i].af_o));
      chk($sformatf("tbl%0d.af_s3", i), 32'(afull1), 32'(tbl[i].af_o));
    end

    // Latch masking with no writes: full three edges after full_dn
    af8 = 3'd3; rp8 = 8'h01; wp8 = 8'h01;
    repeat (5) cycle();
    wp8 = 8'h80;
    cycle(); chk("mask.e1", 32'(full0), 32'd0);
    cycle(); chk("mask.e2", 32'(full0), 32'd0);
    cycle(); chk("mask.e3", 32'(full0), 32'd1);
    wp8 = 8'h01;
    repeat (5) cycle();
    chk("mask.drop", 32'(full0), 32'd0);
    wp8 = 8'h80; valid = 1'b1;
    cycle(); chk("unmask.e1", 32'(full0), 32'd0);
    cycle(); chk("unmask.e2", 32'(full0), 32'd1);
    valid = 1'b0;

    // Overflow set / hold / clr priority
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("ovf.cleared", 32'(ovf0), 32'd0);
    valid = 1'b1; cycle(); valid = 1'b0;
    chk("ovf.set", 32'(ovf0), 32'd1);
    repeat (3) cycle();
    chk("ovf.hold", 32'(ovf0), 32'd1);
    clr = 1'b1; valid = 1'b1; cycle(); valid = 1'b0;
    chk("ovf.set_wins", 32'(ovf0), 32'd1);
    cycle(); clr = 1'b0;
    chk("ovf.clr", 32'(ovf0), 32'd0);

    // Stall counter saturation on the 4-bit instance (GUARD=0, free==0 held)
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("stall.clr", 32'(cnt1), 32'd0);
    repeat (14) cycle();
    chk("stall.14", 32'(cnt1), 32'd14);
    repeat (6) cycle();
    chk("stall.sat", 32'(cnt1), 32'd15);
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("stall.clr_wins", 32'(cnt1), 32'd0);
    cycle();
    chk("stall.restart", 32'(cnt1), 32'd1);

    // Almost-full sweep on depth 16: free = 15 - w with read bit 0
    af16 = 4'd5; rp16 = 16'h0001;
    wp16 = 16'(1) << 8;
    repeat (4) cycle(); chk("af.free7", 32'(afull2), 32'd0);
    wp16 = 16'(1) << 9;
    repeat (4) cycle(); chk("af.free6", 32'(afull2), 32'd0);
    wp16 = 16'(1) << 10;
    cycle(); chk("af.free5.e1", 32'(afull2), 32'd0);
    cycle(); chk("af.free5.e2", 32'(afull2), 32'd1);
    for (int w = 11; w < 16; w++) begin
      wp16 = 16'(1) << w;
      repeat (3) cycle();
      chk($sformatf("af.free%0d", 15 - w), 32'(afull2), 32'd1);
    end
    af16 = 4'd15;
    wp16 = 16'(1) << 8;
    repeat (3) cycle(); chk("af15.free7", 32'(afull2), 32'd1);
    wp16 = 16'h0001;
    repeat (3) cycle(); chk("af15.empty", 32'(afull2), 32'd1);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(49, 0) == 0);
      clr   = ($urandom_range(19, 0) == 0);
      valid = $urandom_range(1, 0) == 1;
      if ($urandom_range(9, 0) == 0) begin
        af8  = 3'($urandom);
        af16 = 4'($urandom);
      end
      if ($urandom_range(2, 0) == 0) begin
        if ($urandom_range(4, 0) == 0) begin
          rp8  = 8'($urandom);  wp8  = 8'($urandom);
          rp16 = 16'($urandom); wp16 = 16'($urandom);
        end else begin
          rp8  = 8'(1) << $urandom_range(7, 0);
          wp8  = 8'(1) << $urandom_range(7, 0);
          rp16 = 16'(1) << $urandom_range(15, 0);
          wp16 = 16'(1) << $urandom_range(15, 0);
        end
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
